// File: rtl/mmss_countdown_if.sv
// mmss_countdown_if: control and display bundle for the MM:SS countdown timer.
//   master : drives en, load, data; observes the digit outputs, zero and done.
//   slave  : the timer itself.
//   en       countdown enable (low = paused)
//   load     digit-entry strobe, one digit per cycle while high
//   data     BCD digit shifted in on load
//   sec_ones seconds units, BCD
//   sec_tens seconds tens, BCD (may exceed 5 after entry)
//   mins     minute digits, BCD, least-significant digit in [3:0]
//   zero     high while every digit is 0
//   done     one-cycle pulse when a countdown reaches 0
interface mmss_countdown_if #(
  parameter int unsigned MIN_DIGITS = 1
) ();
  logic                      en;
  logic                      load;
  logic [3:0]                data;
  logic [3:0]                sec_ones;
  logic [3:0]                sec_tens;
  logic [4*MIN_DIGITS-1:0]   mins;
  logic                      zero;
  logic                      done;

  modport master (
    output en, load, data,
    input  sec_ones, sec_tens, mins, zero, done
  );

  modport slave (
    input  en, load, data,
    output sec_ones, sec_tens, mins, zero, done
  );
endinterface

// File: rtl/mmss_countdown.sv
// mmss_countdown: keypad-entry MM:SS countdown timer with a configurable number of BCD minute
// digits and a tick prescaler.
//   clk   system clock, all state changes on the rising edge
//   clear synchronous active-high reset (digits, prescaler and done to 0)
//   bus   mmss_countdown_if.slave: en/load/data in; sec_ones/sec_tens/mins/zero/done out
// Priority is clear > load > countdown. Digits are held as one packed vector where digit 0 is
// sec_ones, digit 1 is sec_tens and digits 2.. are the minutes, least significant first.
module mmss_countdown #(
  parameter int unsigned MIN_DIGITS = 1,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic            clk,
  input  logic            clear,
  mmss_countdown_if.slave bus
);

  localparam int unsigned NumDigits = MIN_DIGITS + 2;
  localparam int unsigned PsW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(TICK_DIV - 1);

  logic [NumDigits-1:0][3:0] digits_q, digits_d;
  logic [PsW-1:0]            ps_q, ps_d;
  logic                      done_q, done_d;
  logic                      zero;
  logic                      tick;
  logic                      borrow;

  assign zero = (digits_q == '0);

  always_comb begin
    digits_d = digits_q;
    ps_d     = ps_q;
    done_d   = 1'b0;
    tick     = 1'b0;
    borrow   = 1'b1;

    if (bus.load) begin
      // Invalid digits are ignored entirely, but still block the decrement this cycle.
      if (bus.data <= 4'd9) begin
        for (int unsigned i = NumDigits - 1; i > 0; i--) begin
          digits_d[i] = digits_q[i-1];
        end
        digits_d[0] = bus.data;
        ps_d        = '0;
      end
    end else if (zero) begin
      ps_d = '0;
    end else if (bus.en) begin
      if (ps_q == PsLast) begin
        ps_d = '0;
        tick = 1'b1;
      end else begin
        ps_d = ps_q + PsW'(1);
      end
    end

    if (tick) begin
      // Borrow ripples upward; seconds tens wraps to 5, all other digits to 9.
      for (int unsigned i = 0; i < NumDigits; i++) begin
        if (borrow) begin
          if (digits_q[i] == 4'd0) begin
            digits_d[i] = (i == 1) ? 4'd5 : 4'd9;
          end else begin
            digits_d[i] = digits_q[i] - 4'd1;
            borrow      = 1'b0;
          end
        end
      end
      done_d = (digits_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      digits_q <= '0;
      ps_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      ps_q     <= ps_d;
      done_q   <= done_d;
    end
  end

  assign bus.sec_ones = digits_q[0];
  assign bus.sec_tens = digits_q[1];
  assign bus.zero     = zero;
  assign bus.done     = done_q;

  always_comb begin
    bus.mins = '0;
    for (int unsigned i = 0; i < MIN_DIGITS; i++) begin
      bus.mins[4*i +: 4] = digits_q[i+2];
    end
  end

endmodule
